// File: rtl/line_clear_engine_pkg.sv
// Shared playfield definitions for the line-clear engine.
// Holds the grid geometry, cell colour codes (also used by the VGA renderer),
// the engine FSM state type and the row/col -> BRAM address helper.
package line_clear_engine_pkg;

   localparam int GRID_COLS = 20;
   localparam int GRID_ROWS = 15;
   localparam int ADDR_W    = 10;
   localparam int CELL_W    = 4;
   localparam int COL_W     = 5;
   localparam int ROW_W     = 4;

   // Cell colour codes
   localparam logic [CELL_W-1:0] CELL_EMPTY  = 4'h0;
   localparam logic [CELL_W-1:0] CELL_CYAN   = 4'h1;
   localparam logic [CELL_W-1:0] CELL_BLUE   = 4'h2;
   localparam logic [CELL_W-1:0] CELL_ORANGE = 4'h3;
   localparam logic [CELL_W-1:0] CELL_YELLOW = 4'h4;
   localparam logic [CELL_W-1:0] CELL_GREEN  = 4'h5;
   localparam logic [CELL_W-1:0] CELL_PURPLE = 4'h6;
   localparam logic [CELL_W-1:0] CELL_RED    = 4'h7;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COLS - 1);
   localparam logic [COL_W-1:0] COL_END  = COL_W'(GRID_COLS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EVAL,
      ST_WRITE,
      ST_FILL,
      ST_DONE
   } lce_state_e;

   // addr = row*GRID_COLS + col
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(GRID_COLS) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/line_clear_engine_linebuf.sv
// One-row line buffer: GRID_COLS cells of CELL_W bits.
// Ports: clk_i/rst_ni clock and async active-low reset; wr_en_i/wr_idx_i/wr_data_i
// write one cell; rd_idx_i/rd_data_o combinational read (out-of-range reads give
// CELL_EMPTY).
module line_clear_engine_linebuf
   import line_clear_engine_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [COL_W-1:0]  wr_idx_i,
   input  logic [CELL_W-1:0] wr_data_i,
   input  logic [COL_W-1:0]  rd_idx_i,
   output logic [CELL_W-1:0] rd_data_o
);

   logic [CELL_W-1:0] cell_q [GRID_COLS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < GRID_COLS; i++) cell_q[i] <= CELL_EMPTY;
      end else if (wr_en_i && (wr_idx_i < COL_END)) begin
         cell_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = (rd_idx_i < COL_END) ? cell_q[rd_idx_i] : CELL_EMPTY;

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear engine: after a piece locks, scans the playfield BRAM bottom-up,
// drops full rows, compacts the remaining rows downward and fills the vacated
// top rows with CELL_EMPTY.
// Ports: i_Clk/i_Rst_L clock and async active-low reset; i_Start run request
// (IDLE only); o_Busy/o_Done status; o_Lines_Cleared rows removed in last run;
// o_Rd_Addr/i_Rd_Data BRAM read port (1-cycle latency); o_Wr_Addr/o_Wr_Data/
// o_Wr_En BRAM write port. All outputs are registered.
module line_clear_engine
   import line_clear_engine_pkg::*;
(
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_Start,
   output logic              o_Busy,
   output logic              o_Done,
   output logic [3:0]        o_Lines_Cleared,
   output logic [ADDR_W-1:0] o_Rd_Addr,
   input  logic [CELL_W-1:0] i_Rd_Data,
   output logic [ADDR_W-1:0] o_Wr_Addr,
   output logic [CELL_W-1:0] o_Wr_Data,
   output logic              o_Wr_En
);

   lce_state_e        state_q, state_d;
   logic [ROW_W-1:0]  src_q, src_d, dst_q, dst_d;
   logic              dst_uf_q, dst_uf_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              full_q, full_d;
   logic [3:0]        cnt_q, cnt_d;

   logic              busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
   logic [3:0]        lines_q, lines_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [CELL_W-1:0] wr_data_q, wr_data_d;

   logic              advance, dec_dst;
   logic [CELL_W-1:0] buf_rd;

   // Capture side trails the address side by one cycle: col N captures cell N-1.
   line_clear_engine_linebuf u_linebuf (
      .clk_i     (i_Clk),
      .rst_ni    (i_Rst_L),
      .wr_en_i   ((state_q == ST_READ) && (col_q != '0)),
      .wr_idx_i  (col_q - 5'd1),
      .wr_data_i (i_Rd_Data),
      .rd_idx_i  (col_d),
      .rd_data_o (buf_rd)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= ST_IDLE;
         src_q     <= ROW_LAST;
         dst_q     <= ROW_LAST;
         dst_uf_q  <= 1'b0;
         col_q     <= '0;
         full_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         lines_q   <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         dst_uf_q  <= dst_uf_d;
         col_q     <= col_d;
         full_q    <= full_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         lines_q   <= lines_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      dst_uf_d = dst_uf_q;
      col_d    = col_q;
      full_d   = full_q;
      cnt_d    = cnt_q;
      lines_d  = lines_q;
      advance  = 1'b0;
      dec_dst  = 1'b0;

      unique case (state_q)
         ST_IDLE: if (i_Start) begin
            cnt_d    = '0;
            lines_d  = '0;
            src_d    = ROW_LAST;
            dst_d    = ROW_LAST;
            dst_uf_d = 1'b0;
            full_d   = 1'b1;
            col_d    = '0;
            state_d  = ST_READ;
         end
         ST_READ: begin
            if ((col_q != '0) && (i_Rd_Data == CELL_EMPTY)) full_d = 1'b0;
            if (col_q == COL_END) begin
               col_d   = '0;
               state_d = ST_EVAL;
            end else begin
               col_d = col_q + 5'd1;
            end
         end
         ST_EVAL: begin
            if (full_q) begin
               cnt_d   = cnt_q + 4'd1;
               advance = 1'b1;
            end else if (src_q == dst_q) begin
               advance = 1'b1;
               dec_dst = 1'b1;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (col_q == COL_LAST) begin
               advance = 1'b1;
               dec_dst = 1'b1;
            end else begin
               col_d = col_q + 5'd1;
            end
         end
         ST_FILL: begin
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (dst_q == '0) begin
                  dst_uf_d = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  dst_d = dst_q - 4'd1;
               end
            end else begin
               col_d = col_q + 5'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Shared row step for EVAL and WRITE. src only decrements past row 0
      // once the scan is over, so its underflow needs no stored flag.
      if (advance) begin
         col_d = '0;
         if (dec_dst) begin
            if (dst_q == '0) dst_uf_d = 1'b1;
            else             dst_d    = dst_q - 4'd1;
         end
         if (src_q == '0) begin
            state_d = dst_uf_d ? ST_DONE : ST_FILL;
         end else begin
            src_d   = src_q - 4'd1;
            full_d  = 1'b1;
            state_d = ST_READ;
         end
      end

      // Outputs are registered from next-state values so they line up with
      // the state they belong to.
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      if (state_d == ST_DONE) lines_d = cnt_d;
      wr_en_d   = (state_d == ST_WRITE) || (state_d == ST_FILL);
      wr_addr_d = wr_en_d ? cell_addr(dst_d, col_d) : wr_addr_q;
      wr_data_d = (state_d == ST_WRITE) ? buf_rd : CELL_EMPTY;
      rd_addr_d = ((state_d == ST_READ) && (col_d < COL_END)) ? cell_addr(src_d, col_d)
                                                               : rd_addr_q;
   end

   assign o_Busy          = busy_q;
   assign o_Done          = done_q;
   assign o_Lines_Cleared = lines_q;
   assign o_Rd_Addr       = rd_addr_q;
   assign o_Wr_Addr       = wr_addr_q;
   assign o_Wr_Data       = wr_data_q;
   assign o_Wr_En         = wr_en_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a behavioural BRAM model.
module tb_line_clear_engine;

   localparam int COLS  = 20;
   localparam int ROWS  = 15;
   localparam int CELLS = COLS * ROWS;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L;
   logic       i_Start;
   logic       o_Busy, o_Done, o_Wr_En;
   logic [3:0] o_Lines_Cleared, i_Rd_Data, o_Wr_Data;
   logic [9:0] o_Rd_Addr, o_Wr_Addr;

   logic [3:0] mem     [CELLS];
   logic [3:0] orig    [CELLS];
   logic [3:0] exp_mem [CELLS];

   int n_tests = 0;
   int n_fail  = 0;

   always #20 i_Clk = ~i_Clk;

   line_clear_engine dut (
      .i_Clk           (i_Clk),
      .i_Rst_L         (i_Rst_L),
      .i_Start         (i_Start),
      .o_Busy          (o_Busy),
      .o_Done          (o_Done),
      .o_Lines_Cleared (o_Lines_Cleared),
      .o_Rd_Addr       (o_Rd_Addr),
      .i_Rd_Data       (i_Rd_Data),
      .o_Wr_Addr       (o_Wr_Addr),
      .o_Wr_Data       (o_Wr_Data),
      .o_Wr_En         (o_Wr_En)
   );

   // BRAM: synchronous read with 1-cycle latency, one write port
   always @(posedge i_Clk) begin
      i_Rd_Data <= (int'(o_Rd_Addr) < CELLS) ? mem[o_Rd_Addr] : 4'h0;
      if (o_Wr_En && (int'(o_Wr_Addr) < CELLS)) mem[o_Wr_Addr] = o_Wr_Data;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // kind 0: checkerboard 0/1; 1: row 14 full; 2: rows 14,12 full; 3: all full (5)
   task automatic load(input int kind);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            logic [3:0] v;
            case (kind)
               0:       v = 4'((r + c) % 2);
               3:       v = 4'h5;
               default: v = 4'((r * 3 + c) % 7);
            endcase
            if (kind == 1 && r == 14) v = 4'h2;
            if (kind == 2 && (r == 14 || r == 12)) v = 4'h2;
            mem[r*COLS+c]  = v;
            orig[r*COLS+c] = v;
         end
   endtask

   // Reference result: keep non-full rows in order, pack them to the bottom.
   task automatic build_expected();
      int w = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         bit full = 1'b1;
         for (int c = 0; c < COLS; c++) if (orig[r*COLS+c] == 4'h0) full = 1'b0;
         if (!full) begin
            for (int c = 0; c < COLS; c++) exp_mem[w*COLS+c] = orig[r*COLS+c];
            w--;
         end
      end
      for (int r = w; r >= 0; r--)
         for (int c = 0; c < COLS; c++) exp_mem[r*COLS+c] = 4'h0;
   endtask

   function automatic int mem_errors();
      int e = 0;
      for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_mem[i]) e++;
      return e;
   endfunction

   // cyc: cycle (start cycle = 0) in which o_Done was seen; stray: cycle at
   // which a spurious i_Start pulse is applied (0 = none)
   task automatic run(input int stray, output int cyc, output int writes, output bit tmo);
      @(negedge i_Clk) i_Start = 1'b1;
      @(posedge i_Clk);
      cyc = 1; writes = 0; tmo = 1'b1;
      while (cyc < 2000) begin
         @(negedge i_Clk);
         i_Start = (cyc == stray);
         if (o_Wr_En) writes++;
         if (o_Done) begin
            tmo = 1'b0;
            break;
         end
         @(posedge i_Clk);
         cyc++;
      end
      i_Start = 1'b0;
   endtask

   initial begin
      int  cyc, writes;
      bit  tmo, seen;
      i_Rst_L = 1'b0;
      i_Start = 1'b0;
      load(0);

      // reset state, with i_Start pulsed while reset is held
      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk) i_Start = 1'b1;
      @(negedge i_Clk);
      check("rst_busy",  int'(o_Busy), 0);
      check("rst_done",  int'(o_Done), 0);
      check("rst_lines", int'(o_Lines_Cleared), 0);
      check("rst_rdaddr", int'(o_Rd_Addr), 0);
      check("rst_wraddr", int'(o_Wr_Addr), 0);
      check("rst_wrdata", int'(o_Wr_Data), 0);
      check("rst_wren",  int'(o_Wr_En), 0);
      i_Start = 1'b0;
      i_Rst_L = 1'b1;
      repeat (5) @(negedge i_Clk);
      check("post_rst_idle", int'(o_Busy), 0);

      // checkerboard: nothing full
      build_expected();
      run(0, cyc, writes, tmo);
      check("chk_timeout", int'(tmo), 0);
      check("chk_latency", cyc, 331);
      check("chk_lines", int'(o_Lines_Cleared), 0);
      check("chk_busy_done", int'(o_Busy), 1);
      check("chk_writes", writes, 0);
      check("chk_mem", mem_errors(), 0);
      @(negedge i_Clk);
      check("chk_idle", int'(o_Busy), 0);

      // row 14 full
      load(1); build_expected();
      run(0, cyc, writes, tmo);
      check("r14_timeout", int'(tmo), 0);
      check("r14_lines", int'(o_Lines_Cleared), 1);
      check("r14_writes", writes, 300);
      @(negedge i_Clk);
      check("r14_mem", mem_errors(), 0);
      check("r14_row14_is_old13", int'(mem[14*COLS+3]), int'(orig[13*COLS+3]));
      check("r14_row0_empty", int'(mem[5]), 0);

      // rows 14 and 12 full
      load(2); build_expected();
      run(0, cyc, writes, tmo);
      check("r1412_timeout", int'(tmo), 0);
      check("r1412_lines", int'(o_Lines_Cleared), 2);
      check("r1412_writes", writes, 300);
      @(negedge i_Clk);
      check("r1412_mem", mem_errors(), 0);

      // all rows full, stray i_Start while busy
      load(3); build_expected();
      run(50, cyc, writes, tmo);
      check("all_timeout", int'(tmo), 0);
      check("all_lines", int'(o_Lines_Cleared), 15);
      check("all_latency", cyc, 631);
      check("all_writes", writes, 300);
      @(negedge i_Clk);
      check("all_mem", mem_errors(), 0);
      repeat (3) @(negedge i_Clk);
      check("all_no_restart", int'(o_Busy), 0);

      // reset asserted in the middle of a WRITE row
      load(1);
      @(negedge i_Clk) i_Start = 1'b1;
      @(negedge i_Clk) i_Start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge i_Clk);
         if (o_Wr_En) seen = 1'b1;
      end
      check("mid_wr_seen", int'(seen), 1);
      repeat (5) @(posedge i_Clk);
      #3 i_Rst_L = 1'b0;
      #1;
      check("mid_rst_wren", int'(o_Wr_En), 0);
      check("mid_rst_busy", int'(o_Busy), 0);
      @(negedge i_Clk) i_Rst_L = 1'b1;
      repeat (4) @(negedge i_Clk);
      check("mid_rst_idle", int'(o_Busy), 0);
      check("mid_rst_nodone", int'(o_Done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
